// File: rtl/mc_control.sv
// Multi-cycle main control FSM for the MIPS datapath.
// Moore-decoded datapath strobes per state; bad_op flags an unsupported opcode in DECODE.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | after reset, all strobes low
// FETCH  | read instruction, PC <= PC+4 when memory ready
// DECODE | register read, branch target into ALUOut
// MEMADR | effective address computation for LW/SW
// MEMRD  | data memory read, wait for ready
// MEMWB  | load write-back from MDR
// MEMWR  | data memory write, wait for ready
// REXEC  | R-type ALU operation
// RWB    | R-type write-back
// BEQ    | branch compare and conditional PC update
// JUMP   | unconditional jump
// LINK   | balrz: link PC into rd, branch to rs if zero
module mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       balrz,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       link_sel,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       aluop1,
    output logic       aluop0,
    output logic [1:0] pcsource,
    output logic [3:0] state_o,
    output logic       bad_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_REXEC  = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BEQ    = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_LINK   = 4'd11;

    logic [3:0] state;
    logic [3:0] state_next;

    // State register; reset lands in IDLE so every strobe drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_REXEC;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  state_next = balrz ? S_LINK : S_RWB;
            S_RWB:    state_next = S_FETCH;
            S_BEQ:    state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_LINK:   state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode; FETCH gates its register writes on memory ready so a stalled
    // fetch never latches a stale instruction or advances the PC twice.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        link_sel    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop1      = 1'b0;
        aluop0      = 1'b0;
        pcsource    = 2'b00;
        bad_op      = 1'b0;
        case (state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                bad_op  = !((op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                            (op == OP_BEQ) || (op == OP_J));
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_REXEC: begin
                alusrca = 1'b1;
                aluop1  = 1'b1;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQ: begin
                alusrca     = 1'b1;
                aluop0      = 1'b1;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            S_LINK: begin
                regwrite    = 1'b1;
                regdst      = 1'b1;
                link_sel    = 1'b1;
                pcwritecond = 1'b1;
                pcsource    = 2'b11;
                aluop0      = 1'b1;
                alusrca     = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: each driven cycle pushes the expected state/strobe vector,
// a negedge monitor pops and compares it against the DUT.
module tb_mc_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       balrz;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       regwrite, regdst, memtoreg, link_sel, alusrca;
    logic [1:0] alusrcb;
    logic       aluop1, aluop0;
    logic [1:0] pcsource;
    logic [3:0] state_o;
    logic       bad_op;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;

    exp_t sb[$];

    logic [21:0] x_idle, x_fwait, x_fgo, x_dec, x_dbad, x_madr, x_mrd, x_mwb;
    logic [21:0] x_mwr, x_rexec, x_rwb, x_beq, x_jump, x_link;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .balrz(balrz), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .link_sel(link_sel), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop1(aluop1), .aluop0(aluop0), .pcsource(pcsource), .state_o(state_o),
        .bad_op(bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Field order: state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
    // regwrite, regdst, memtoreg, link_sel, alusrca, alusrcb, aluop, pcsource, bad_op
    function automatic logic [21:0] mk(input logic [3:0] st, input logic pw, input logic pwc,
                                       input logic io, input logic mr, input logic mw,
                                       input logic irw, input logic rw, input logic rd,
                                       input logic m2r, input logic ls, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [1:0] pcs, input logic bad);
        return {st, pw, pwc, io, mr, mw, irw, rw, rd, m2r, ls, asa, asb, aop, pcs, bad};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {state_o, pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                regwrite, regdst, memtoreg, link_sel, alusrca, alusrcb,
                aluop1, aluop0, pcsource, bad_op};
    endfunction

    // One cycle: drive inputs just after the rising edge and queue the expectation.
    task automatic step(input string tag, input logic rv, input logic [5:0] o,
                        input logic b, input logic mr, input logic [21:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = rv;
        op        = o;
        balrz     = b;
        mem_ready = mr;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
    endtask

    // Scoreboard consumer, mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk(x.tag, {10'd0, dut_vec()}, {10'd0, x.v});
        end
    end

    initial begin
        x_idle  = mk(4'd0,  0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        x_fwait = mk(4'd1,  0,0,0,1,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
        x_fgo   = mk(4'd1,  1,0,0,1,0,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
        x_dec   = mk(4'd2,  0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0);
        x_dbad  = mk(4'd2,  0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 1);
        x_madr  = mk(4'd3,  0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
        x_mrd   = mk(4'd4,  0,0,1,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        x_mwb   = mk(4'd5,  0,0,0,0,0,0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 0);
        x_mwr   = mk(4'd6,  0,0,1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        x_rexec = mk(4'd7,  0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0);
        x_rwb   = mk(4'd8,  0,0,0,0,0,0,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        x_beq   = mk(4'd9,  0,1,0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0);
        x_jump  = mk(4'd10, 1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0);
        x_link  = mk(4'd11, 0,1,0,0,0,0,1,1,0,1,1, 2'b00, 2'b01, 2'b11, 0);

        rst_n = 1'b0; op = 6'd0; balrz = 1'b0; mem_ready = 1'b0;

        // Reset and release: IDLE until the first edge after release
        step("rst0",    0, 6'h00, 0, 1, x_idle);
        step("rst1",    0, 6'h00, 0, 1, x_idle);
        step("rel",     1, 6'h23, 0, 0, x_idle);
        // LW with one fetch stall, then 1,2,3,4,5
        step("lw_fw",   1, 6'h23, 0, 0, x_fwait);
        step("lw_f",    1, 6'h23, 0, 1, x_fgo);
        step("lw_d",    1, 6'h23, 0, 1, x_dec);
        step("lw_ma",   1, 6'h23, 0, 1, x_madr);
        step("lw_rd",   1, 6'h23, 0, 1, x_mrd);
        step("lw_wb",   1, 6'h23, 0, 1, x_mwb);
        // R-type balrz: 1,2,7,11
        step("bz_f",    1, 6'h00, 1, 1, x_fgo);
        step("bz_d",    1, 6'h00, 1, 1, x_dec);
        step("bz_ex",   1, 6'h00, 1, 1, x_rexec);
        step("bz_lk",   1, 6'h00, 1, 1, x_link);
        // Plain R-type: 1,2,7,8
        step("r_f",     1, 6'h00, 0, 1, x_fgo);
        step("r_d",     1, 6'h00, 0, 1, x_dec);
        step("r_ex",    1, 6'h00, 0, 1, x_rexec);
        step("r_wb",    1, 6'h00, 0, 1, x_rwb);
        // SW with 3 not-ready cycles in MEMWR: 4 cycles in state 6
        step("sw_f",    1, 6'h2b, 0, 1, x_fgo);
        step("sw_d",    1, 6'h2b, 0, 1, x_dec);
        step("sw_ma",   1, 6'h2b, 0, 1, x_madr);
        step("sw_w0",   1, 6'h2b, 0, 0, x_mwr);
        step("sw_w1",   1, 6'h2b, 0, 0, x_mwr);
        step("sw_w2",   1, 6'h2b, 0, 0, x_mwr);
        step("sw_w3",   1, 6'h2b, 0, 1, x_mwr);
        // Unsupported opcode: bad_op in DECODE, back to FETCH
        step("bad_f",   1, 6'h3f, 0, 1, x_fgo);
        step("bad_d",   1, 6'h3f, 0, 1, x_dbad);
        // BEQ: 1,2,9
        step("beq_f",   1, 6'h04, 0, 1, x_fgo);
        step("beq_d",   1, 6'h04, 0, 1, x_dec);
        step("beq_x",   1, 6'h04, 0, 1, x_beq);
        // J: 1,2,10
        step("j_f",     1, 6'h02, 0, 1, x_fgo);
        step("j_d",     1, 6'h02, 0, 1, x_dec);
        step("j_x",     1, 6'h02, 0, 1, x_jump);
        // LW with one MEMRD stall
        step("lws_f",   1, 6'h23, 0, 1, x_fgo);
        step("lws_d",   1, 6'h23, 0, 1, x_dec);
        step("lws_ma",  1, 6'h23, 0, 1, x_madr);
        step("lws_r0",  1, 6'h23, 0, 0, x_mrd);
        step("lws_r1",  1, 6'h23, 0, 1, x_mrd);
        step("lws_wb",  1, 6'h23, 0, 1, x_mwb);
        // SW aborted by reset while stalled in MEMWR
        step("ab_f",    1, 6'h2b, 0, 1, x_fgo);
        step("ab_d",    1, 6'h2b, 0, 1, x_dec);
        step("ab_ma",   1, 6'h2b, 0, 1, x_madr);
        step("ab_w",    1, 6'h2b, 0, 0, x_mwr);
        step("ab_rst",  0, 6'h2b, 0, 0, x_idle);
        step("ab_rel",  1, 6'h2b, 0, 0, x_idle);
        step("ab_fet",  1, 6'h2b, 0, 1, x_fgo);

        repeat (3) @(posedge clk);
        chk("drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
